wb_write_arbiter: RTL and testbench

Writeback-side driver of the 32x32 register file write port (regWrite/writeReg/writeData, sampled by the register file on the falling clock edge).
- Merges two producers onto that single write port:
  - the in-order pipeline (MEM/WB results, including sign/zero-extended loads);
  - the multi-cycle multiply/divide unit, which returns GPR results out of band.
- Buffers multiply/divide results in a 2-entry FIFO.
- Exposes pending-destination lookups so the hazard unit can stall readers.

---
 rtl/wb_write_arbiter.sv | 178 +++++++++++++++++
 tb/tb_wb_write_arbiter.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/wb_write_arbiter.sv
// wb_write_arbiter: drives the register-file write port from two producers.
// The in-order pipeline result wins every edge. Multiply/divide results wait
// in a small FIFO and drain on idle edges. A pipeline write kills older FIFO
// entries that target the same register.
// Optional build macro: WB_FORWARD_EN adds fwd_* copies of the write port for
// EX forwarding, and removes the output entry from the hit1/hit2 lookups.
module wb_write_arbiter #(
    parameter int FIFO_DEPTH = 2,
    parameter int REG_ADDR_W = 5,
    parameter int DATA_W     = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wb_valid,
    input  logic                  wb_regWrite,
    input  logic                  wb_memToReg,
    input  logic [2:0]            wb_loadType,
    input  logic [REG_ADDR_W-1:0] wb_writeReg,
    input  logic [DATA_W-1:0]     wb_aluResult,
    input  logic [DATA_W-1:0]     wb_memData,
    input  logic                  md_valid,
    output logic                  md_ready,
    input  logic [REG_ADDR_W-1:0] md_writeReg,
    input  logic [DATA_W-1:0]     md_result,
    input  logic [REG_ADDR_W-1:0] query1,
    input  logic [REG_ADDR_W-1:0] query2,
    output logic                  hit1,
    output logic                  hit2,
    output logic                  regWrite,
    output logic [REG_ADDR_W-1:0] writeReg,
    output logic [DATA_W-1:0]     writeData
`ifdef WB_FORWARD_EN
    ,
    output logic                  fwd_valid,
    output logic [REG_ADDR_W-1:0] fwd_reg,
    output logic [DATA_W-1:0]     fwd_data
`endif
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    logic                  ent_valid_reg [FIFO_DEPTH];
    logic [REG_ADDR_W-1:0] ent_dst_reg   [FIFO_DEPTH];
    logic [DATA_W-1:0]     ent_data_reg  [FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr_reg, rd_ptr_reg;
    logic [CNT_W-1:0]      count_reg;

    logic                  regwrite_reg;
    logic [REG_ADDR_W-1:0] writereg_reg;
    logic [DATA_W-1:0]     writedata_reg;
    logic                  out_md_reg;   // output currently holds a FIFO result

    logic                  pipe_wr;
    logic                  pop;
    logic                  enq;
    logic [DATA_W-1:0]     pipe_data;
    logic [7:0]            ld_byte;
    logic [15:0]           ld_half;
    logic [FIFO_DEPTH-1:0] match1, match2;

    assign md_ready = !rst && (count_reg < CNT_W'(FIFO_DEPTH));
    assign pipe_wr  = wb_valid && wb_regWrite && (wb_writeReg != '0);
    assign pop      = !pipe_wr && (count_reg != '0);
    // r0 results complete the handshake but never occupy a slot
    assign enq      = md_valid && md_ready && (md_writeReg != '0);

    // Big-endian lane select and sign/zero extension for loads
    always_comb begin
        ld_byte   = wb_memData[DATA_W-1 -: 8];
        ld_half   = wb_aluResult[1] ? wb_memData[15:0] : wb_memData[DATA_W-1 -: 16];
        pipe_data = wb_aluResult;
        case (wb_aluResult[1:0])
            2'd0:    ld_byte = wb_memData[DATA_W-1 -: 8];
            2'd1:    ld_byte = wb_memData[DATA_W-9 -: 8];
            2'd2:    ld_byte = wb_memData[15:8];
            default: ld_byte = wb_memData[7:0];
        endcase
        if (wb_memToReg) begin
            case (wb_loadType)
                3'b001:  pipe_data = {{(DATA_W-8){ld_byte[7]}}, ld_byte};
                3'b010:  pipe_data = {{(DATA_W-8){1'b0}}, ld_byte};
                3'b011:  pipe_data = {{(DATA_W-16){ld_half[15]}}, ld_half};
                3'b100:  pipe_data = {{(DATA_W-16){1'b0}}, ld_half};
                default: pipe_data = wb_memData;
            endcase
        end
    end

    generate
        for (genvar gi = 0; gi < FIFO_DEPTH; gi++) begin : g_slot
            // Slot liveness: set on push, cleared on pop or by a newer pipeline write
            always_ff @(posedge clk) begin
                if (rst) begin
                    ent_valid_reg[gi] <= 1'b0;
                end else if (enq && (wr_ptr_reg == PTR_W'(gi))) begin
                    ent_valid_reg[gi] <= 1'b1;
                end else if (pop && (rd_ptr_reg == PTR_W'(gi))) begin
                    ent_valid_reg[gi] <= 1'b0;
                end else if (pipe_wr && (ent_dst_reg[gi] == wb_writeReg)) begin
                    ent_valid_reg[gi] <= 1'b0;
                end
            end

            assign match1[gi] = ent_valid_reg[gi] && (ent_dst_reg[gi] == query1);
            assign match2[gi] = ent_valid_reg[gi] && (ent_dst_reg[gi] == query2);
        end
    endgenerate

    // Payload storage: written on enqueue only, no reset needed
    always_ff @(posedge clk) begin
        if (enq) begin
            ent_dst_reg[wr_ptr_reg]  <= md_writeReg;
            ent_data_reg[wr_ptr_reg] <= md_result;
        end
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (enq) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            if (pop) rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            case ({enq, pop})
                2'b10:   count_reg <= count_reg + CNT_W'(1);
                2'b01:   count_reg <= count_reg - CNT_W'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

    // Registered write port: pipeline first, then FIFO head, else idle
    always_ff @(posedge clk) begin
        if (rst) begin
            regwrite_reg  <= 1'b0;
            writereg_reg  <= '0;
            writedata_reg <= '0;
            out_md_reg    <= 1'b0;
        end else if (pipe_wr) begin
            regwrite_reg  <= 1'b1;
            writereg_reg  <= wb_writeReg;
            writedata_reg <= pipe_data;
            out_md_reg    <= 1'b0;
        end else if (pop) begin
            regwrite_reg <= ent_valid_reg[rd_ptr_reg];
            out_md_reg   <= ent_valid_reg[rd_ptr_reg];
            if (ent_valid_reg[rd_ptr_reg]) begin
                writereg_reg  <= ent_dst_reg[rd_ptr_reg];
                writedata_reg <= ent_data_reg[rd_ptr_reg];
            end
        end else begin
            regwrite_reg <= 1'b0;
            out_md_reg   <= 1'b0;
        end
    end

    assign regWrite  = regwrite_reg;
    assign writeReg  = writereg_reg;
    assign writeData = writedata_reg;

`ifdef WB_FORWARD_EN
    assign fwd_valid = regwrite_reg;
    assign fwd_reg   = writereg_reg;
    assign fwd_data  = writedata_reg;
    assign hit1 = (query1 != '0) && ((|match1) || (enq && (md_writeReg == query1)));
    assign hit2 = (query2 != '0) && ((|match2) || (enq && (md_writeReg == query2)));
`else
    // The entry on the outputs counts as pending until the regfile has it
    assign hit1 = (query1 != '0) && ((|match1) || (enq && (md_writeReg == query1)) ||
                                     (out_md_reg && (writereg_reg == query1)));
    assign hit2 = (query2 != '0) && ((|match2) || (enq && (md_writeReg == query2)) ||
                                     (out_md_reg && (writereg_reg == query2)));
`endif

endmodule

// File: tb/tb_wb_write_arbiter.sv
// tb_wb_write_arbiter: directed plus randomized stimulus; a queue-based model
// predicts one write-port outcome per cycle, and a negedge monitor compares.
module tb_wb_write_arbiter;
    localparam int D = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        wb_valid, wb_regWrite, wb_memToReg;
    logic [2:0]  wb_loadType;
    logic [4:0]  wb_writeReg;
    logic [31:0] wb_aluResult, wb_memData;
    logic        md_valid, md_ready;
    logic [4:0]  md_writeReg;
    logic [31:0] md_result;
    logic [4:0]  query1, query2;
    logic        hit1, hit2;
    logic        regWrite;
    logic [4:0]  writeReg;
    logic [31:0] writeData;
`ifdef WB_FORWARD_EN
    logic        fwd_valid;
    logic [4:0]  fwd_reg;
    logic [31:0] fwd_data;
`endif

    int checks = 0;
    int errors = 0;

    typedef struct { logic [4:0] r; logic [31:0] d; bit v; } ent_t;
    typedef struct { bit rw; bit z; logic [4:0] r; logic [31:0] d; } exp_t;
    ent_t mq[$];       // model FIFO contents, oldest first
    exp_t exp_q[$];    // expected write-port state, one per cycle
    bit         last_md = 0;
    logic [4:0] last_reg = '0;
    logic [4:0] regs [5] = '{5'd0, 5'd5, 5'd6, 5'd7, 5'd9};

    always #5 clk = ~clk;

    wb_write_arbiter #(.FIFO_DEPTH(D), .REG_ADDR_W(5), .DATA_W(32)) dut (
        .clk(clk), .rst(rst),
        .wb_valid(wb_valid), .wb_regWrite(wb_regWrite), .wb_memToReg(wb_memToReg),
        .wb_loadType(wb_loadType), .wb_writeReg(wb_writeReg),
        .wb_aluResult(wb_aluResult), .wb_memData(wb_memData),
        .md_valid(md_valid), .md_ready(md_ready), .md_writeReg(md_writeReg),
        .md_result(md_result), .query1(query1), .query2(query2),
        .hit1(hit1), .hit2(hit2),
        .regWrite(regWrite), .writeReg(writeReg), .writeData(writeData)
`ifdef WB_FORWARD_EN
        , .fwd_valid(fwd_valid), .fwd_reg(fwd_reg), .fwd_data(fwd_data)
`endif
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Load result from the lane rules, using shifts and plain arithmetic
    function automatic logic [31:0] load_value(input logic mtr, input logic [2:0] lt,
                                               input logic [31:0] a, input logic [31:0] m);
        int unsigned sh;
        logic [31:0] b;
        if (!mtr) return a;
        case (lt)
            3'd1, 3'd2: begin
                sh = (3 - int'(a[1:0])) * 8;
                b  = (m >> sh) & 32'hFF;
                if (lt == 3'd1 && b >= 32'd128) b = b - 32'd256;
            end
            3'd3, 3'd4: begin
                sh = a[1] ? 0 : 16;
                b  = (m >> sh) & 32'hFFFF;
                if (lt == 3'd3 && b >= 32'd32768) b = b - 32'd65536;
            end
            default: b = m;
        endcase
        return b;
    endfunction

    function automatic bit model_hit(input logic [4:0] q, input bit ready);
        if (q == 0) return 0;
        foreach (mq[i]) if (mq[i].v && mq[i].r == q) return 1;
        if (md_valid && ready && md_writeReg == q) return 1;
`ifndef WB_FORWARD_EN
        if (last_md && last_reg == q) return 1;
`endif
        return 0;
    endfunction

    // One clock: check combinational outputs, predict the edge, advance
    task automatic step();
        bit   ready, pipe;
        exp_t e;
        ent_t h;
        #1;
        ready = !rst && (mq.size() < D);
        chk("md_ready", 32'(md_ready), 32'(ready));
        chk("hit1", 32'(hit1), 32'(model_hit(query1, ready)));
        chk("hit2", 32'(hit2), 32'(model_hit(query2, ready)));
        e = '{rw: 0, z: 0, r: '0, d: '0};
        if (rst) begin
            mq.delete();
            last_md = 0;
            e.z = 1;
        end else begin
            pipe = wb_valid && wb_regWrite && wb_writeReg != 0;
            last_md = 0;
            if (pipe) begin
                e.rw = 1; e.r = wb_writeReg;
                e.d  = load_value(wb_memToReg, wb_loadType, wb_aluResult, wb_memData);
                foreach (mq[i]) if (mq[i].r == wb_writeReg) mq[i].v = 0;
            end else if (mq.size() > 0) begin
                h = mq.pop_front();
                if (h.v) begin
                    e.rw = 1; e.r = h.r; e.d = h.d;
                    last_md = 1; last_reg = h.r;
                end
            end
            if (md_valid && ready && md_writeReg != 0)
                mq.push_back('{r: md_writeReg, d: md_result, v: 1});
        end
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    // Monitor: one expectation per cycle, compared mid-cycle
    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL monitor: write port active with no expectation at %0t", $time);
        end else begin
            e = exp_q.pop_front();
            chk("regWrite", 32'(regWrite), 32'(e.rw));
            if (e.rw || e.z) begin
                chk("writeReg", 32'(writeReg), 32'(e.r));
                chk("writeData", writeData, e.d);
            end
`ifdef WB_FORWARD_EN
            chk("fwd_valid", 32'(fwd_valid), 32'(regWrite));
            chk("fwd_reg", 32'(fwd_reg), 32'(writeReg));
            chk("fwd_data", fwd_data, writeData);
`endif
            if (e.rw) $display("write r%0d = %h (expected r%0d = %h)", writeReg, writeData, e.r, e.d);
            else      $display("idle regWrite=%0b%s", regWrite, e.z ? " (reset)" : "");
        end
    end

    task automatic idle();
        wb_valid = 0; wb_regWrite = 0; wb_memToReg = 0; wb_loadType = 0;
        wb_writeReg = 0; wb_aluResult = 0; wb_memData = 0;
        md_valid = 0; md_writeReg = 0; md_result = 0;
    endtask

    task automatic pipe_wr(input logic [4:0] r, input logic [31:0] a);
        wb_valid = 1; wb_regWrite = 1; wb_memToReg = 0; wb_writeReg = r; wb_aluResult = a;
    endtask

    task automatic md_push(input logic [4:0] r, input logic [31:0] d);
        md_valid = 1; md_writeReg = r; md_result = d;
    endtask

    initial begin
        rst = 1; query1 = 0; query2 = 0;
        idle();
        step(); step();
        rst = 0;
        step();                                   // md_ready rises after reset

        // Plain ALU write
        pipe_wr(5'd9, 32'h1234); step();
        idle(); step();

        // Load extension
        pipe_wr(5'd3, 32'h1); wb_memToReg = 1; wb_memData = 32'h80FF7F01;
        wb_loadType = 3'b001; step();
        wb_loadType = 3'b010; step();
        wb_aluResult = 32'h2; wb_loadType = 3'b011; step();
        wb_aluResult = 32'h0; wb_loadType = 3'b100; step();
        wb_aluResult = 32'h3; wb_loadType = 3'b110; step();
        idle(); step();

        // Two md pushes while pipeline is busy, then drain
        pipe_wr(5'd9, 32'h1); md_push(5'd5, 32'hAAAA); step();
        pipe_wr(5'd9, 32'h2); md_push(5'd6, 32'hBBBB); step();
        md_valid = 0; query1 = 5; query2 = 6; pipe_wr(5'd9, 32'h3); step();
        idle(); step(); step(); step();

        // WAW kill of a queued r7
        pipe_wr(5'd9, 32'h4); md_push(5'd7, 32'h7777); query1 = 7; step();
        md_valid = 0; pipe_wr(5'd7, 32'h11); step();
        idle(); step(); step();

        // r0 on both producers
        query1 = 0; query2 = 0;
        pipe_wr(5'd0, 32'hDEAD); md_push(5'd0, 32'hBEEF); step();
        idle(); step(); step();

        // Reset with a full FIFO and busy pipeline
        query1 = 5; query2 = 6;
        pipe_wr(5'd9, 32'h5); md_push(5'd5, 32'h55); step();
        pipe_wr(5'd9, 32'h6); md_push(5'd6, 32'h66); step();
        pipe_wr(5'd9, 32'h7); md_push(5'd7, 32'h77); rst = 1; step();
        rst = 0; idle(); step(); step();

        // Randomized traffic
        for (int n = 0; n < 400; n++) begin
            wb_valid     = ($urandom_range(0, 99) < 55);
            wb_regWrite  = ($urandom_range(0, 99) < 85);
            wb_memToReg  = $urandom_range(0, 1);
            wb_loadType  = 3'($urandom_range(0, 7));
            wb_writeReg  = regs[$urandom_range(0, 4)];
            wb_aluResult = $urandom;
            wb_memData   = $urandom;
            md_valid     = ($urandom_range(0, 99) < 40);
            md_writeReg  = regs[$urandom_range(0, 3)];
            md_result    = $urandom;
            query1       = regs[$urandom_range(0, 4)];
            query2       = regs[$urandom_range(0, 4)];
            if (wb_valid && wb_regWrite && md_writeReg == wb_writeReg) md_valid = 0;
            rst = ($urandom_range(0, 99) == 0);
            step();
        end
        rst = 0; idle(); step(); step(); step();

        @(negedge clk); #1;
        chk("exp_queue_drained", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
